// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NUM_CH prescaled auto-reload up-counters with one-shot mode,
// per-channel W1C update flags and a merged level interrupt.
module apb_timer_mc #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;

  logic              en    [NUM_CH];
  logic              opm   [NUM_CH];
  logic              irqen [NUM_CH];
  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [CNT_W-1:0]  psc   [NUM_CH];
  logic [CNT_W-1:0]  arr   [NUM_CH];
  logic [CNT_W-1:0]  pcnt  [NUM_CH];
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irqen_vec;

  logic              acc, wr;
  logic [2:0]        sel_ch;
  logic [1:0]        sel_reg;
  logic              ch_space, stat_sel;
  logic [NUM_CH-1:0] hit, tick, cr_wr, clr_wr, cnt_wr, psc_wr, arr_wr, wrap;
  logic [NUM_CH-1:0] w1c;
  logic              unused_ok;

  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE;
  assign PREADY   = acc;
  assign sel_ch   = PADDR[6:4];
  assign sel_reg  = PADDR[3:2];
  assign ch_space = ~PADDR[7];
  assign stat_sel = (PADDR[7:2] == 6'h20);
  assign w1c      = (wr && stat_sel) ? PWDATA[NUM_CH-1:0] : '0;
  assign unused_ok = ^{PADDR[1:0], PWDATA};

  // Per-channel address decode, prescaler tick and wrap detection.
  always_comb begin
    hit       = '0;
    tick      = '0;
    cr_wr     = '0;
    clr_wr    = '0;
    cnt_wr    = '0;
    psc_wr    = '0;
    arr_wr    = '0;
    wrap      = '0;
    irqen_vec = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      hit[n]       = ch_space && (sel_ch == 3'(n));
      tick[n]      = en[n] && (pcnt[n] >= psc[n]);
      cr_wr[n]     = wr && hit[n] && (sel_reg == 2'd0);
      clr_wr[n]    = cr_wr[n] && PWDATA[1];
      cnt_wr[n]    = wr && hit[n] && (sel_reg == 2'd1);
      psc_wr[n]    = wr && hit[n] && (sel_reg == 2'd2);
      arr_wr[n]    = wr && hit[n] && (sel_reg == 2'd3);
      // A CLR or a CNT write pre-empts the tick, so no flag and no one-shot stop.
      wrap[n]      = tick[n] && (cnt[n] >= arr[n]) && !clr_wr[n] && !cnt_wr[n];
      irqen_vec[n] = irqen[n];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int n = 0; n < NUM_CH; n++) begin
        en[n]    <= 1'b0;
        opm[n]   <= 1'b0;
        irqen[n] <= 1'b0;
        cnt[n]   <= '0;
        psc[n]   <= '0;
        arr[n]   <= '0;
        pcnt[n]  <= '0;
      end
      status <= '0;
      irq    <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        // A CR write overrides the one-shot auto-stop in the same cycle.
        if (cr_wr[n]) begin
          en[n]    <= PWDATA[0];
          opm[n]   <= PWDATA[2];
          irqen[n] <= PWDATA[3];
        end else if (wrap[n] && opm[n]) begin
          en[n] <= 1'b0;
        end

        if (clr_wr[n] || tick[n]) begin
          pcnt[n] <= '0;
        end else if (en[n]) begin
          pcnt[n] <= pcnt[n] + CNT_W'(1);
        end

        if (clr_wr[n]) begin
          cnt[n] <= '0;
        end else if (cnt_wr[n]) begin
          cnt[n] <= PWDATA[CNT_W-1:0];
        end else if (wrap[n]) begin
          cnt[n] <= '0;
        end else if (tick[n]) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end

        if (psc_wr[n]) psc[n] <= PWDATA[CNT_W-1:0];
        if (arr_wr[n]) arr[n] <= PWDATA[CNT_W-1:0];
      end
      // Hardware set wins over a coincident W1C.
      status <= (status & ~w1c) | wrap;
      irq    <= |(status & irqen_vec);
    end
  end

  // Read mux; zero outside the access phase and for unmapped addresses.
  always_comb begin
    PRDATA = '0;
    if (acc) begin
      if (stat_sel) begin
        PRDATA = DATA_W'(status);
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (hit[n]) begin
            case (sel_reg)
              2'd0:    PRDATA = {28'd0, irqen[n], opm[n], 1'b0, en[n]};
              2'd1:    PRDATA = DATA_W'(cnt[n]);
              2'd2:    PRDATA = DATA_W'(psc[n]);
              default: PRDATA = DATA_W'(arr[n]);
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed self-checking bench for apb_timer_mc: a 32-bit-counter instance and a
// 16-bit-counter instance share the APB bus; tgt selects which one is addressed.
module tb_apb_timer_mc;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PENABLE, PSEL;
  logic        tgt;
  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, rdata;
  logic        pready_a, pready_b, ready;
  logic        irq, irq_b;

  int n_checks = 0;
  int n_pass   = 0;

  assign psel_a = PSEL & ~tgt;
  assign psel_b = PSEL & tgt;
  assign rdata  = tgt ? prdata_b : prdata_a;
  assign ready  = tgt ? pready_b : pready_a;

  apb_timer_mc #(.NUM_CH(2), .CNT_W(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(psel_a), .PRDATA(prdata_a), .PREADY(pready_a), .irq(irq)
  );

  apb_timer_mc #(.NUM_CH(2), .CNT_W(16)) dut16 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(psel_b), .PRDATA(prdata_b), .PREADY(pready_b), .irq(irq_b)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Full APB write; commits at the second edge, returns 1 time unit after it.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    #1 check($sformatf("pready_wr_%02h", a), 32'(ready), 32'd1);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Full APB read with PREADY and PRDATA checks in the access phase.
  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    #1;
    check({tag, "_pready"}, 32'(ready), 32'd1);
    check(tag, rdata, exp);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Zero-time observation of a register between clock edges.
  task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string tag);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    #1 check(tag, rdata, exp);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    int exp_seq[4];
    exp_seq = '{1, 2, 3, 0};
    tgt = 1'b0; PRESET = 1'b1; PADDR = '0; PWDATA = '0;
    PWRITE = 1'b0; PENABLE = 1'b0; PSEL = 1'b0;
    step(3);
    PRESET = 1'b0;
    step();

    // Reset state
    check("idle_pready", 32'(ready), 32'd0);
    check("idle_prdata", rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    peek(8'h00, 32'd0, "rst_cr0");
    peek(8'h14, 32'd0, "rst_cnt1");
    peek(8'h80, 32'd0, "rst_status");

    // 1: ch0 free-running, PSC=0 ARR=3
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h9);
    peek(8'h04, 32'd0, "t1_cnt0");
    for (int i = 0; i < 4; i++) begin
      step();
      peek(8'h04, 32'(exp_seq[i]), $sformatf("t1_cnt%0d", i + 1));
    end
    peek(8'h80, 32'h1, "t1_status_wrap");
    check("t1_irq_wrap", 32'(irq), 32'd0);
    step();
    check("t1_irq_next", 32'(irq), 32'd1);
    wr(8'h00, 32'h8);

    // 2: ch1 one-shot, tick every 5 cycles
    wr(8'h18, 32'd4);
    wr(8'h1C, 32'd2);
    wr(8'h10, 32'h5);
    for (int k = 1; k <= 3; k++) begin
      step(4);
      peek(8'h14, 32'(k - 1), $sformatf("t2_pre_tick%0d", k));
      step();
      peek(8'h14, (k == 3) ? 32'd0 : 32'(k), $sformatf("t2_tick%0d", k));
    end
    peek(8'h10, 32'h4, "t2_cr1_stopped");
    peek(8'h80, 32'h3, "t2_status");
    step(10);
    peek(8'h14, 32'd0, "t2_cnt1_hold");

    // 3: W1C and irq merge
    wr(8'h80, 32'h1);
    peek(8'h80, 32'h2, "t3_w1c");
    step();
    check("t3_irq_off", 32'(irq), 32'd0);
    wr(8'h10, 32'h8);
    step();
    check("t3_irq_ch1", 32'(irq), 32'd1);
    wr(8'h00, 32'hB);
    step(2);
    wr(8'h80, 32'h1);
    peek(8'h80, 32'h3, "t3_set_beats_w1c");
    peek(8'h04, 32'd0, "t3_cnt0_wrapped");
    wr(8'h00, 32'h8);

    // 4: lowering ARR below CNT, then CLR mid-count
    wr(8'h80, 32'h3);
    wr(8'h00, 32'h2);
    wr(8'h08, 32'd100);
    wr(8'h0C, 32'd10);
    wr(8'h04, 32'd7);
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'd5);
    wr(8'h08, 32'd0);
    peek(8'h04, 32'd7, "t4_cnt_before");
    peek(8'h80, 32'h0, "t4_status_before");
    step();
    peek(8'h04, 32'd0, "t4_arr_wrap");
    peek(8'h80, 32'h1, "t4_arr_flag");
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h3);
    peek(8'h04, 32'd0, "t4_clr_cnt");
    peek(8'h00, 32'h1, "t4_clr_cr");
    step(3);
    peek(8'h04, 32'd0, "t4_pcnt_cleared");
    step();
    peek(8'h04, 32'd1, "t4_first_tick");

    // 5: CNT write beats tick, unmapped space, narrow counter
    wr(8'h08, 32'd0);
    wr(8'h04, 32'h55);
    peek(8'h04, 32'h55, "t5_cnt_write");
    step();
    peek(8'h04, 32'd0, "t5_cnt_wrap");
    wr(8'h00, 32'h0);
    rd(8'h40, 32'd0, "t5_rd_ch4");
    wr(8'h40, 32'hFFFF_FFFF);
    wr(8'h24, 32'h1234);
    rd(8'h40, 32'd0, "t5_rd_ch4_after_wr");
    rd(8'h24, 32'd0, "t5_rd_ch2");
    rd(8'h84, 32'd0, "t5_rd_unmapped");
    rd(8'h04, 32'd2, "t5_cnt0_untouched");
    rd(8'h00, 32'd0, "t5_cr0_untouched");
    tgt = 1'b1;
    wr(8'h04, 32'h12345);
    rd(8'h04, 32'h2345, "t5_cnt16_trunc");
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(8'h0C, 32'hFFFF, "t5_arr16_trunc");
    tgt = 1'b0;

    // 6: reset during a counting run
    wr(8'h80, 32'h1);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h9);
    step(6);
    check("t6_irq_running", 32'(irq), 32'd1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    check("t6_irq_rst", 32'(irq), 32'd0);
    peek(8'h00, 32'd0, "t6_cr0");
    peek(8'h04, 32'd0, "t6_cnt0");
    peek(8'h08, 32'd0, "t6_psc0");
    peek(8'h0C, 32'd0, "t6_arr0");
    peek(8'h18, 32'd0, "t6_psc1");
    peek(8'h1C, 32'd0, "t6_arr1");
    peek(8'h80, 32'd0, "t6_status");
    step(3);
    peek(8'h04, 32'd0, "t6_cnt0_idle");
    check("t6_irq_idle", 32'(irq), 32'd0);
    rd(8'h00, 32'd0, "t6_rd_cr0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
